// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle ripple adder/subtractor, CHUNK bits per clock.
// Carry is registered between chunks; start/busy/done handshake.
`timescale 1ns/1ps
module seq_addsub #(
   parameter int WIDTH = 25,
   parameter int CHUNK = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             ovf
);

   localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int NP = N * CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            r_state, w_next;
   logic [1:0]        r_rst_sync;
   logic              w_rst_n;
   logic [NP-1:0]     r_a, r_b, r_res;
   logic [NP-1:0]     w_in1x, w_bx, w_res_nxt;
   logic [IW-1:0]     r_idx;
   logic              r_c;
   logic [CHUNK-1:0]  w_sum;
   logic              w_c, w_cmsb, w_last, w_accept;
   logic [WIDTH-1:0]  r_S;
   logic              r_Cout, r_ovf, r_done;
   int                w_base;

   // Async assert, clock-synchronised release of the internal reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= '0;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_state == RUN) && (r_idx == IW'(N - 1));

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start)  w_next = RUN;
         RUN:     if (w_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_in1x = '0;
      w_bx   = '0;
      w_in1x[WIDTH-1:0] = in1;
      w_bx[WIDTH-1:0]   = sub ? ~in2 : in2;
   end

   // One chunk of ripple; bits past WIDTH-1 leave the carry untouched
   always_comb begin
      w_c    = r_c;
      w_cmsb = 1'b0;
      w_sum  = '0;
      w_base = int'(r_idx) * CHUNK;
      for (int j = 0; j < CHUNK; j++) begin
         if (w_base + j < WIDTH) begin
            if (w_base + j == WIDTH - 1) w_cmsb = w_c;
            w_sum[j] = r_a[j] ^ r_b[j] ^ w_c;
            w_c = (r_a[j] & r_b[j]) | (w_c & (r_a[j] ^ r_b[j]));
         end
      end
   end

   always_comb begin
      w_res_nxt = r_res;
      for (int k = 0; k < N; k++) begin
         if (r_idx == IW'(k)) w_res_nxt[k*CHUNK +: CHUNK] = w_sum;
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_idx  <= '0;
         r_c    <= 1'b0;
         r_S    <= '0;
         r_Cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (1'b1)
            w_accept: begin
               r_a   <= w_in1x;
               r_b   <= w_bx;
               r_c   <= sub ? 1'b1 : cin;
               r_idx <= '0;
            end
            (r_state == RUN): begin
               r_a   <= r_a >> CHUNK;
               r_b   <= r_b >> CHUNK;
               r_c   <= w_c;
               r_res <= w_res_nxt;
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_S    <= w_res_nxt[WIDTH-1:0];
                  r_Cout <= w_c;
                  r_ovf  <= w_cmsb ^ w_c;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state == RUN);
   assign done = r_done;
   assign S    = r_S;
   assign Cout = r_Cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: 25/5 and 8/3 instances.
// Stimulus pushes expected results; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_seq_addsub;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   int total = 0;
   int passed = 0;

   logic        a_start, a_sub, a_cin, a_busy, a_done, a_Cout, a_ovf;
   logic [24:0] a_in1, a_in2, a_S;
   logic        b_start, b_sub, b_cin, b_busy, b_done, b_Cout, b_ovf;
   logic [7:0]  b_in1, b_in2, b_S;

   seq_addsub #(.WIDTH(25), .CHUNK(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .sub(a_sub),
      .in1(a_in1), .in2(a_in2), .cin(a_cin), .busy(a_busy),
      .done(a_done), .S(a_S), .Cout(a_Cout), .ovf(a_ovf));

   seq_addsub #(.WIDTH(8), .CHUNK(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .sub(b_sub),
      .in1(b_in1), .in2(b_in2), .cin(b_cin), .busy(b_busy),
      .done(b_done), .S(b_S), .Cout(b_Cout), .ovf(b_ovf));

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        v;
      int          t;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int runa = 0;
   int runb = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", n, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) runa = 0;
      else begin
         if (a_busy) runa++;
         if (a_done) begin
            if (qa.size() == 0) begin
               total++;
               $display("FAIL a_unexpected_done: got done at %0d, expected none", cnt);
            end else begin
               e = qa.pop_front();
               chk("a_S", 32'(a_S), e.s);
               chk("a_Cout", 32'(a_Cout), 32'(e.c));
               chk("a_ovf", 32'(a_ovf), 32'(e.v));
               chk("a_latency", cnt, e.t);
               chk("a_busy_cycles", runa, 5);
            end
            runa = 0;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) runb = 0;
      else begin
         if (b_busy) runb++;
         if (b_done) begin
            if (qb.size() == 0) begin
               total++;
               $display("FAIL b_unexpected_done: got done at %0d, expected none", cnt);
            end else begin
               e = qb.pop_front();
               chk("b_S", 32'(b_S), e.s);
               chk("b_Cout", 32'(b_Cout), 32'(e.c));
               chk("b_ovf", 32'(b_ovf), 32'(e.v));
               chk("b_latency", cnt, e.t);
               chk("b_busy_cycles", runb, 3);
            end
            runb = 0;
         end
      end
   end

   task automatic issue_a(bit now, bit push, bit s, logic [31:0] x,
                          logic [31:0] y, bit ci, logic [31:0] es,
                          bit ec, bit ev);
      exp_t e;
      if (!now) @(negedge clk);
      a_start = 1'b1; a_sub = s; a_cin = ci;
      a_in1 = x[24:0]; a_in2 = y[24:0];
      e.s = es; e.c = ec; e.v = ev; e.t = cnt + 1 + 5;
      if (push) qa.push_back(e);
      @(negedge clk);
      a_start = 1'b0; a_sub = ~s; a_cin = ~ci;
      a_in1 = ~x[24:0]; a_in2 = ~y[24:0];
   endtask

   task automatic issue_b(bit s, logic [31:0] x, logic [31:0] y, bit ci,
                          logic [31:0] es, bit ec, bit ev);
      exp_t e;
      @(negedge clk);
      b_start = 1'b1; b_sub = s; b_cin = ci;
      b_in1 = x[7:0]; b_in2 = y[7:0];
      e.s = es; e.c = ec; e.v = ev; e.t = cnt + 1 + 3;
      qb.push_back(e);
      @(negedge clk);
      b_start = 1'b0; b_sub = ~s; b_cin = ~ci;
      b_in1 = ~x[7:0]; b_in2 = ~y[7:0];
   endtask

   task automatic wait_a();
      for (int i = 0; i < 40 && qa.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("a_drain", qa.size(), 0);
      qa.delete();
   endtask

   task automatic wait_b();
      for (int i = 0; i < 40 && qb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("b_drain", qb.size(), 0);
      qb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_start = 0; a_sub = 0; a_cin = 0; a_in1 = '0; a_in2 = '0;
      b_start = 0; b_sub = 0; b_cin = 0; b_in1 = '0; b_in2 = '0;
      #2;
      chk("rst_a_S", 32'(a_S), 0);
      chk("rst_a_busy", 32'(a_busy), 0);
      chk("rst_a_done", 32'(a_done), 0);
      chk("rst_a_Cout", 32'(a_Cout), 0);
      chk("rst_b_S", 32'(b_S), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      issue_a(0, 1, 0, 'h1FFFFFF, 'h1, 0, 'h0, 1, 0);        wait_a();
      issue_a(0, 1, 1, 10, 3, 0, 7, 1, 0);                   wait_a();
      issue_a(0, 1, 1, 10, 3, 1, 7, 1, 0);                   wait_a();
      issue_a(0, 1, 1, 3, 10, 0, 'h1FFFFF9, 0, 0);           wait_a();
      issue_a(0, 1, 0, 'h0FFFFFF, 'h1, 0, 'h1000000, 0, 1);  wait_a();
      issue_a(0, 1, 0, 0, 0, 1, 1, 0, 0);                    wait_a();
      issue_a(0, 1, 1, 'h1000000, 1, 0, 'h0FFFFFF, 1, 1);    wait_a();

      // start during RUN must be ignored
      issue_a(0, 1, 0, 5, 7, 1, 13, 0, 0);
      @(negedge clk);
      a_start = 1'b1; a_sub = 1'b1; a_in1 = 25'd99; a_in2 = 25'd4;
      @(negedge clk);
      a_start = 1'b0;
      wait_a();

      // back-to-back: second start in the done cycle
      issue_a(0, 1, 0, 'h123456, 'h111111, 0, 'h234567, 0, 0);
      for (int i = 0; i < 20 && !a_done; i++) @(negedge clk);
      chk("a_b2b_done", 32'(a_done), 1);
      issue_a(1, 1, 0, 'h1FFFFFF, 'h1FFFFFF, 1, 'h1FFFFFF, 1, 0);
      wait_a();

      issue_b(0, 'hFF, 'h01, 0, 'h00, 1, 0); wait_b();
      issue_b(0, 'h7F, 'h01, 0, 'h80, 0, 1); wait_b();
      issue_b(1, 'h05, 'h09, 0, 'hFC, 0, 0); wait_b();

      // reset in cycle 2 of RUN aborts; outputs clear at once
      issue_a(0, 0, 1, 10, 3, 0, 7, 1, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_S", 32'(a_S), 0);
      chk("abort_Cout", 32'(a_Cout), 0);
      chk("abort_busy", 32'(a_busy), 0);
      chk("abort_done", 32'(a_done), 0);
      chk("abort_ovf", 32'(a_ovf), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      issue_a(0, 1, 0, 'h0ABCDE, 'h1, 0, 'h0ABCDF, 0, 0);
      wait_a();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
